// File: rtl/load_store_ctrl_seq_pkg.sv
// Shared types for the load/store control sequencer: access width, beat bundle, FSM state.
// Optional statistics counters are enabled by defining LS_CTRL_STATS_EN.
package load_store_ctrl_seq_pkg;

  typedef enum logic [1:0] {
    Load_byte  = 2'd0,
    Load_half  = 2'd1,
    Load_word  = 2'd2,
    Load_dword = 2'd3
  } Load_mode;

  localparam Load_mode LOAD_MODE_RESET = Load_word;

  // Beat register index is carried at a fixed maximum width; the top trims it to REG_W.
  localparam int LS_REG_W_MAX = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_MULTI = 1'b1
  } ls_seq_state_e;

  typedef struct packed {
    logic                    we;
    Load_mode                mode;
    logic                    multiple;
    logic                    first_cycle;
    logic                    multiple_inc;
    logic [LS_REG_W_MAX-1:0] reg_idx;
    logic                    return_dout;
    logic                    keep_eff_addr;
    logic                    exts;
    logic                    is_update_op;
    logic                    do_request;
    logic                    last;
  } Ls_ctrl_bundle;

  function automatic Ls_ctrl_bundle ls_bundle_reset();
    Ls_ctrl_bundle b;
    b      = '0;
    b.mode = LOAD_MODE_RESET;
    return b;
  endfunction

endpackage

// File: rtl/load_store_ctrl_seq_ls_ctrl_delay.sv
// DEPTH-stage valid/bundle shift register; stall holds every stage, flush invalidates all.
// Invalid output stage presents the reset bundle.
module load_store_ctrl_seq_ls_ctrl_delay
  import load_store_ctrl_seq_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic          clk,
  input  logic          resetb,
  input  logic          i_stall,
  input  logic          i_flush,
  input  logic          i_valid,
  input  Ls_ctrl_bundle i_bundle,
  output logic          o_valid,
  output Ls_ctrl_bundle o_bundle
);

  logic [DEPTH-1:0] r_valid;
  Ls_ctrl_bundle    r_data [DEPTH];

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) r_data[i] <= ls_bundle_reset();
    end else if (i_flush) begin
      r_valid <= '0;
    end else if (!i_stall) begin
      r_valid[0] <= i_valid;
      r_data[0]  <= i_bundle;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_data[i]  <= r_data[i-1];
      end
    end
  end

  assign o_valid  = r_valid[DEPTH-1];
  assign o_bundle = r_valid[DEPTH-1] ? r_data[DEPTH-1] : ls_bundle_reset();

endmodule

// File: rtl/load_store_ctrl_seq.sv
// Registered load/store control: sequences lmw/stmw beats and delays the bundle DEPTH stages.
// Define LS_CTRL_STATS_EN to add saturating stat_loads/stat_stores beat counters.
module load_store_ctrl_seq
  import load_store_ctrl_seq_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter int NREG  = 32,
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             en_dec,
  input  logic             we,
  input  Load_mode         mode,
  input  logic             multiple,
  input  logic [REG_W-1:0] rt,
  input  logic             return_dout,
  input  logic             keep_eff_addr,
  input  logic             exts,
  input  logic             is_update_op,
  input  logic             do_request,
  input  logic             stall,
  input  logic             dis_ex,
  output logic             busy,
  output logic             ls_en,
  output logic             ls_we,
  output logic             ls_multiple,
  output logic             ls_first_cycle,
  output logic             ls_multiple_inc,
  output Load_mode         ls_mode,
  output logic [REG_W-1:0] ls_reg,
  output logic             ls_return_dout,
  output logic             ls_keep_eff_addr,
  output logic             ls_exts,
  output logic             ls_is_update_op,
  output logic             ls_do_request,
  output logic             ls_last,
`ifdef LS_CTRL_STATS_EN
  output logic [31:0]      stat_loads,
  output logic [31:0]      stat_stores,
`endif
  output ls_seq_state_e    dbg_state
);

  localparam logic [REG_W-1:0] LAST_REG = REG_W'(NREG - 1);

  ls_seq_state_e    r_state, w_state_nxt;
  logic [REG_W-1:0] r_cnt, w_cnt_nxt;
  Ls_ctrl_bundle    r_lat, w_lat_nxt;
  Ls_ctrl_bundle    w_in, w_beat, w_out;
  logic             w_beat_valid, w_out_valid;

  always_comb begin
    w_in               = ls_bundle_reset();
    w_in.we            = we;
    w_in.mode          = mode;
    w_in.multiple      = multiple;
    w_in.first_cycle   = 1'b1;
    w_in.multiple_inc  = 1'b0;
    w_in.reg_idx       = LS_REG_W_MAX'(rt);
    w_in.return_dout   = return_dout;
    w_in.keep_eff_addr = keep_eff_addr;
    w_in.exts          = exts;
    w_in.is_update_op  = is_update_op;
    w_in.do_request    = do_request;
    w_in.last          = !multiple || (rt == LAST_REG);
  end

  // Handshake: decode may only present en_dec while busy=0; a beat is taken on a cycle
  // with neither stall nor dis_ex, otherwise decode keeps en_dec and its operands steady.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_lat_nxt    = r_lat;
    w_beat_valid = 1'b0;
    w_beat       = ls_bundle_reset();
    busy         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = en_dec && multiple && (rt != LAST_REG);
        if (en_dec && !stall && !dis_ex) begin
          w_beat_valid = 1'b1;
          w_beat       = w_in;
          if (multiple && (rt != LAST_REG)) begin
            w_state_nxt = ST_MULTI;
            w_cnt_nxt   = rt + REG_W'(1);
            w_lat_nxt   = w_in;
          end
        end
      end
      ST_MULTI: begin
        busy = 1'b1;
        if (!stall && !dis_ex) begin
          w_beat_valid        = 1'b1;
          w_beat              = r_lat;
          w_beat.first_cycle  = 1'b0;
          w_beat.multiple_inc = 1'b1;
          w_beat.reg_idx      = LS_REG_W_MAX'(r_cnt);
          w_beat.last         = (r_cnt == LAST_REG);
          if (r_cnt == LAST_REG) w_state_nxt = ST_IDLE;
          else                   w_cnt_nxt   = r_cnt + REG_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (dis_ex) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_lat   <= ls_bundle_reset();
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_lat   <= w_lat_nxt;
    end
  end

  load_store_ctrl_seq_ls_ctrl_delay #(.DEPTH(DEPTH)) u_delay (
    .clk      (clk),
    .resetb   (resetb),
    .i_stall  (stall),
    .i_flush  (dis_ex),
    .i_valid  (w_beat_valid),
    .i_bundle (w_beat),
    .o_valid  (w_out_valid),
    .o_bundle (w_out)
  );

  assign dbg_state        = r_state;
  assign ls_en            = w_out_valid;
  assign ls_we            = w_out.we;
  assign ls_multiple      = w_out.multiple;
  assign ls_first_cycle   = w_out.first_cycle;
  assign ls_multiple_inc  = w_out.multiple_inc;
  assign ls_mode          = w_out.mode;
  assign ls_reg           = w_out.reg_idx[REG_W-1:0];
  assign ls_return_dout   = w_out.return_dout;
  assign ls_keep_eff_addr = w_out.keep_eff_addr;
  assign ls_exts          = w_out.exts;
  assign ls_is_update_op  = w_out.is_update_op;
  assign ls_do_request    = w_out.do_request;
  assign ls_last          = w_out.last;

  logic w_unused_reg;
  assign w_unused_reg = ^w_out.reg_idx;

`ifdef LS_CTRL_STATS_EN
  // A beat is counted once, in the cycle it leaves the output (not while held by stall).
  logic        w_beat_done;
  logic [31:0] r_loads, r_stores;
  assign w_beat_done = w_out_valid && (!stall || dis_ex);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_loads  <= '0;
      r_stores <= '0;
    end else if (w_beat_done) begin
      if (!w_out.we && (r_loads != '1))  r_loads  <= r_loads + 32'd1;
      if (w_out.we && (r_stores != '1))  r_stores <= r_stores + 32'd1;
    end
  end

  assign stat_loads  = r_loads;
  assign stat_stores = r_stores;
`endif

  a_no_issue_while_multi: assert property (
    @(posedge clk) disable iff (!resetb) (r_state == ST_MULTI) |-> !en_dec
  );

endmodule

// File: tb/tb_load_store_ctrl_seq.sv
// Directed bench for load_store_ctrl_seq with a DEPTH=1 and a DEPTH=2 instance on shared inputs.
// Stats checks compile in when LS_CTRL_STATS_EN is defined.
module tb_load_store_ctrl_seq;
  import load_store_ctrl_seq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetb, en_dec, we, multiple, stall, dis_ex;
  Load_mode   mode;
  logic [4:0] rt;
  logic       return_dout, keep_eff_addr, exts, is_update_op, do_request;

  logic a_busy, a_en, a_we, a_mul, a_first, a_inc, a_last;
  logic a_rd, a_kea, a_exts, a_upd, a_req;
  logic [4:0] a_reg;
  Load_mode a_mode;
  ls_seq_state_e a_state;
  logic b_busy, b_en, b_we, b_mul, b_first, b_inc, b_last;
  logic b_rd, b_kea, b_exts, b_upd, b_req;
  logic [4:0] b_reg;
  Load_mode b_mode;
  ls_seq_state_e b_state;
`ifdef LS_CTRL_STATS_EN
  logic [31:0] a_loads, a_stores, b_loads, b_stores;
`endif

  int total = 0;
  int bad   = 0;
  logic [10:0] exp_v;

  wire [10:0] a_obs = {a_en, a_we, a_mul, a_first, a_inc, a_last, a_reg};
  wire [10:0] b_obs = {b_en, b_we, b_mul, b_first, b_inc, b_last, b_reg};
  wire [4:0]  a_pt  = {a_rd, a_kea, a_exts, a_upd, a_req};
  wire [4:0]  b_pt  = {b_rd, b_kea, b_exts, b_upd, b_req};

  load_store_ctrl_seq #(.DEPTH(1), .NREG(32), .REG_W(5)) u_d1 (
    .clk(clk), .resetb(resetb), .en_dec(en_dec), .we(we), .mode(mode), .multiple(multiple),
    .rt(rt), .return_dout(return_dout), .keep_eff_addr(keep_eff_addr), .exts(exts),
    .is_update_op(is_update_op), .do_request(do_request), .stall(stall), .dis_ex(dis_ex),
    .busy(a_busy), .ls_en(a_en), .ls_we(a_we), .ls_multiple(a_mul), .ls_first_cycle(a_first),
    .ls_multiple_inc(a_inc), .ls_mode(a_mode), .ls_reg(a_reg), .ls_return_dout(a_rd),
    .ls_keep_eff_addr(a_kea), .ls_exts(a_exts), .ls_is_update_op(a_upd),
    .ls_do_request(a_req), .ls_last(a_last),
`ifdef LS_CTRL_STATS_EN
    .stat_loads(a_loads), .stat_stores(a_stores),
`endif
    .dbg_state(a_state)
  );

  load_store_ctrl_seq #(.DEPTH(2), .NREG(32), .REG_W(5)) u_d2 (
    .clk(clk), .resetb(resetb), .en_dec(en_dec), .we(we), .mode(mode), .multiple(multiple),
    .rt(rt), .return_dout(return_dout), .keep_eff_addr(keep_eff_addr), .exts(exts),
    .is_update_op(is_update_op), .do_request(do_request), .stall(stall), .dis_ex(dis_ex),
    .busy(b_busy), .ls_en(b_en), .ls_we(b_we), .ls_multiple(b_mul), .ls_first_cycle(b_first),
    .ls_multiple_inc(b_inc), .ls_mode(b_mode), .ls_reg(b_reg), .ls_return_dout(b_rd),
    .ls_keep_eff_addr(b_kea), .ls_exts(b_exts), .ls_is_update_op(b_upd),
    .ls_do_request(b_req), .ls_last(b_last),
`ifdef LS_CTRL_STATS_EN
    .stat_loads(b_loads), .stat_stores(b_stores),
`endif
    .dbg_state(b_state)
  );

  // Packs {en, we, multiple, first_cycle, multiple_inc, last, reg} as the bench sees a beat.
  function automatic logic [10:0] bt(input logic en, input logic w, input logic mul,
                                     input logic first, input logic inc, input logic last,
                                     input logic [4:0] r);
    return {en, w, mul, first, inc, last, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    en_dec = 1'b0; we = 1'b0; multiple = 1'b0; rt = 5'd0; mode = Load_word;
    stall = 1'b0; dis_ex = 1'b0;
    {return_dout, keep_eff_addr, exts, is_update_op, do_request} = 5'b0;
  endtask

  task automatic issue(input logic st, input logic mul, input logic [4:0] r);
    en_dec = 1'b1; we = st; multiple = mul; rt = r;
  endtask

  task automatic test_reset();
    resetb = 1'b0;
    drive_idle();
    #12;
    total++; if (a_obs !== 11'd0) begin bad++; $display("FAIL rst_a_obs got=%h exp=0", a_obs); end
    total++; if (b_obs !== 11'd0) begin bad++; $display("FAIL rst_b_obs got=%h exp=0", b_obs); end
    total++; if (a_mode !== Load_word || b_mode !== Load_word) begin bad++; $display("FAIL rst_mode got=%0d/%0d exp=%0d", a_mode, b_mode, Load_word); end
    total++; if (a_pt !== 5'd0 || b_pt !== 5'd0) begin bad++; $display("FAIL rst_pt got=%b/%b exp=0", a_pt, b_pt); end
    total++; if (a_busy !== 1'b0 || b_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b/%b exp=0", a_busy, b_busy); end
    total++; if (b_state !== ST_IDLE) begin bad++; $display("FAIL rst_state got=%0d exp=%0d", b_state, ST_IDLE); end
`ifdef LS_CTRL_STATS_EN
    total++; if (a_loads !== 32'd0 || b_stores !== 32'd0) begin bad++; $display("FAIL rst_stats got=%0d/%0d exp=0", a_loads, b_stores); end
`endif
    #1 resetb = 1'b1;
    tick();
    total++; if (b_obs !== 11'd0) begin bad++; $display("FAIL rst_rel_b got=%h exp=0", b_obs); end
  endtask

  task automatic test_single_load();
    issue(1'b0, 1'b0, 5'd3);
    mode = Load_half;
    {return_dout, keep_eff_addr, exts, is_update_op, do_request} = 5'b10101;
    #1;
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL lhz_busy got=%b exp=0", a_busy); end
    tick();
    drive_idle();
    exp_v = bt(1, 0, 0, 1, 0, 1, 5'd3);
    total++; if (a_obs !== exp_v) begin bad++; $display("FAIL lhz_d1_beat got=%h exp=%h", a_obs, exp_v); end
    total++; if (a_pt !== 5'b10101) begin bad++; $display("FAIL lhz_d1_pt got=%b exp=10101", a_pt); end
    total++; if (a_mode !== Load_half) begin bad++; $display("FAIL lhz_d1_mode got=%0d exp=%0d", a_mode, Load_half); end
    total++; if (b_obs !== 11'd0) begin bad++; $display("FAIL lhz_d2_early got=%h exp=0", b_obs); end
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL lhz_busy1 got=%b exp=0", a_busy); end
    tick();
    total++; if (a_obs !== 11'd0) begin bad++; $display("FAIL lhz_d1_after got=%h exp=0", a_obs); end
    total++; if (b_obs !== exp_v) begin bad++; $display("FAIL lhz_d2_beat got=%h exp=%h", b_obs, exp_v); end
    total++; if (b_pt !== 5'b10101) begin bad++; $display("FAIL lhz_d2_pt got=%b exp=10101", b_pt); end
    tick();
    total++; if (b_obs !== 11'd0) begin bad++; $display("FAIL lhz_d2_after got=%h exp=0", b_obs); end
  endtask

  task automatic test_lmw_29();
    issue(1'b0, 1'b1, 5'd29);
    #1;
    total++; if (b_busy !== 1'b1) begin bad++; $display("FAIL lmw29_busy_c0 got=%b exp=1", b_busy); end
    tick();
    drive_idle();
    total++; if (b_busy !== 1'b1) begin bad++; $display("FAIL lmw29_busy_c1 got=%b exp=1", b_busy); end
    total++; if (b_state !== ST_MULTI) begin bad++; $display("FAIL lmw29_state_c1 got=%0d exp=%0d", b_state, ST_MULTI); end
    total++; if (b_obs !== 11'd0) begin bad++; $display("FAIL lmw29_d2_c1 got=%h exp=0", b_obs); end
    exp_v = bt(1, 0, 1, 1, 0, 0, 5'd29);
    total++; if (a_obs !== exp_v) begin bad++; $display("FAIL lmw29_d1_c1 got=%h exp=%h", a_obs, exp_v); end
    tick();
    total++; if (b_busy !== 1'b1) begin bad++; $display("FAIL lmw29_busy_c2 got=%b exp=1", b_busy); end
    total++; if (b_obs !== exp_v) begin bad++; $display("FAIL lmw29_r29 got=%h exp=%h", b_obs, exp_v); end
    tick();
    total++; if (b_busy !== 1'b0) begin bad++; $display("FAIL lmw29_busy_c3 got=%b exp=0", b_busy); end
    exp_v = bt(1, 0, 1, 0, 1, 0, 5'd30);
    total++; if (b_obs !== exp_v) begin bad++; $display("FAIL lmw29_r30 got=%h exp=%h", b_obs, exp_v); end
    tick();
    exp_v = bt(1, 0, 1, 0, 1, 1, 5'd31);
    total++; if (b_obs !== exp_v) begin bad++; $display("FAIL lmw29_r31 got=%h exp=%h", b_obs, exp_v); end
    tick();
    total++; if (b_obs !== 11'd0) begin bad++; $display("FAIL lmw29_end got=%h exp=0", b_obs); end
  endtask

  task automatic test_lmw_31();
    issue(1'b0, 1'b1, 5'd31);
    #1;
    total++; if (b_busy !== 1'b0) begin bad++; $display("FAIL lmw31_busy_c0 got=%b exp=0", b_busy); end
    tick();
    drive_idle();
    exp_v = bt(1, 0, 1, 1, 0, 1, 5'd31);
    total++; if (a_obs !== exp_v) begin bad++; $display("FAIL lmw31_d1 got=%h exp=%h", a_obs, exp_v); end
    total++; if (b_state !== ST_IDLE || b_busy !== 1'b0) begin bad++; $display("FAIL lmw31_idle got=%0d/%b exp=0/0", b_state, b_busy); end
    tick();
    total++; if (b_obs !== exp_v) begin bad++; $display("FAIL lmw31_d2 got=%h exp=%h", b_obs, exp_v); end
    tick();
    total++; if (b_obs !== 11'd0) begin bad++; $display("FAIL lmw31_end got=%h exp=0", b_obs); end
  endtask

  task automatic test_stall();
    issue(1'b1, 1'b1, 5'd28);
    tick();
    drive_idle();
    tick();
    exp_v = bt(1, 1, 1, 1, 0, 0, 5'd28);
    total++; if (b_obs !== exp_v) begin bad++; $display("FAIL stmw_r28 got=%h exp=%h", b_obs, exp_v); end
    tick();
    exp_v = bt(1, 1, 1, 0, 1, 0, 5'd29);
    total++; if (b_obs !== exp_v) begin bad++; $display("FAIL stmw_r29 got=%h exp=%h", b_obs, exp_v); end
    stall = 1'b1;
    #1;
    total++; if (b_busy !== 1'b1) begin bad++; $display("FAIL stmw_busy_stall got=%b exp=1", b_busy); end
    tick();
    total++; if (b_obs !== exp_v) begin bad++; $display("FAIL stmw_r29_held got=%h exp=%h", b_obs, exp_v); end
    total++; if (b_state !== ST_MULTI) begin bad++; $display("FAIL stmw_state_held got=%0d exp=%0d", b_state, ST_MULTI); end
    stall = 1'b0;
    tick();
    exp_v = bt(1, 1, 1, 0, 1, 0, 5'd30);
    total++; if (b_obs !== exp_v) begin bad++; $display("FAIL stmw_r30 got=%h exp=%h", b_obs, exp_v); end
    tick();
    exp_v = bt(1, 1, 1, 0, 1, 1, 5'd31);
    total++; if (b_obs !== exp_v) begin bad++; $display("FAIL stmw_r31 got=%h exp=%h", b_obs, exp_v); end
    tick();
    total++; if (b_obs !== 11'd0) begin bad++; $display("FAIL stmw_end got=%h exp=0", b_obs); end
    // issue under stall must not be taken until stall drops
    issue(1'b0, 1'b0, 5'd7);
    stall = 1'b1;
    tick();
    total++; if (a_obs !== 11'd0) begin bad++; $display("FAIL stall_issue_blocked got=%h exp=0", a_obs); end
    stall = 1'b0;
    tick();
    drive_idle();
    exp_v = bt(1, 0, 0, 1, 0, 1, 5'd7);
    total++; if (a_obs !== exp_v) begin bad++; $display("FAIL stall_issue_taken got=%h exp=%h", a_obs, exp_v); end
    tick();
    total++; if (a_obs !== 11'd0) begin bad++; $display("FAIL stall_issue_once got=%h exp=0", a_obs); end
    tick();
  endtask

  task automatic test_flush();
    issue(1'b1, 1'b1, 5'd20);
    tick();
    drive_idle();
    tick();
    exp_v = bt(1, 1, 1, 1, 0, 0, 5'd20);
    total++; if (b_obs !== exp_v) begin bad++; $display("FAIL flush_r20 got=%h exp=%h", b_obs, exp_v); end
    tick();
    exp_v = bt(1, 1, 1, 0, 1, 0, 5'd21);
    total++; if (b_obs !== exp_v) begin bad++; $display("FAIL flush_r21 got=%h exp=%h", b_obs, exp_v); end
    exp_v = bt(1, 1, 1, 0, 1, 0, 5'd22);
    total++; if (a_obs !== exp_v) begin bad++; $display("FAIL flush_d1_r22 got=%h exp=%h", a_obs, exp_v); end
    dis_ex = 1'b1;
    tick();
    dis_ex = 1'b0;
    total++; if (a_obs !== 11'd0 || b_obs !== 11'd0) begin bad++; $display("FAIL flush_killed got=%h/%h exp=0/0", a_obs, b_obs); end
    total++; if (b_busy !== 1'b0 || b_state !== ST_IDLE) begin bad++; $display("FAIL flush_idle got=%b/%0d exp=0/0", b_busy, b_state); end
    issue(1'b0, 1'b0, 5'd5);
    tick();
    drive_idle();
    total++; if (b_obs !== 11'd0) begin bad++; $display("FAIL flush_no_stale got=%h exp=0", b_obs); end
    tick();
    exp_v = bt(1, 0, 0, 1, 0, 1, 5'd5);
    total++; if (b_obs !== exp_v) begin bad++; $display("FAIL flush_new_lwz got=%h exp=%h", b_obs, exp_v); end
    tick();
    total++; if (b_obs !== 11'd0) begin bad++; $display("FAIL flush_end got=%h exp=0", b_obs); end
  endtask

  task automatic test_async_reset();
    issue(1'b0, 1'b1, 5'd10);
    tick();
    drive_idle();
    tick();
    exp_v = bt(1, 0, 1, 1, 0, 0, 5'd10);
    total++; if (b_obs !== exp_v) begin bad++; $display("FAIL arst_pre got=%h exp=%h", b_obs, exp_v); end
    #3 resetb = 1'b0;
    #1;
    total++; if (a_obs !== 11'd0 || b_obs !== 11'd0) begin bad++; $display("FAIL arst_outs got=%h/%h exp=0/0", a_obs, b_obs); end
    total++; if (b_state !== ST_IDLE || b_busy !== 1'b0) begin bad++; $display("FAIL arst_fsm got=%0d/%b exp=0/0", b_state, b_busy); end
`ifdef LS_CTRL_STATS_EN
    total++; if (b_loads !== 32'd0 || b_stores !== 32'd0) begin bad++; $display("FAIL arst_stats got=%0d/%0d exp=0", b_loads, b_stores); end
`endif
    #3 resetb = 1'b1;
    tick();
    total++; if (b_obs !== 11'd0 || b_state !== ST_IDLE) begin bad++; $display("FAIL arst_release got=%h/%0d exp=0/0", b_obs, b_state); end
    tick();
    total++; if (b_obs !== 11'd0) begin bad++; $display("FAIL arst_quiet got=%h exp=0", b_obs); end
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_lmw_29();
    test_lmw_31();
    test_stall();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
